btn_conditioner: RTL



---
 rtl/btn_conditioner.sv | 111 +++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Five-channel push-button conditioner: synchronize, debounce, then emit a clean
// level, a one-cycle press pulse and a press-plus-auto-repeat enable per channel.
module btn_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_scen,
    output logic [N_BTN-1:0] btn_mcen
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DB_CNT  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RD_CNT  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RP_CNT  = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        state_t        state_q, state_d;
        logic          s1_q, s2_q;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [CW-1:0] rep_q, rep_d, rep_inc, rep_target;
        logic          rep_phase_q, rep_phase_d;
        logic          db_q, db_d, scen_q, scen_d, mcen_q, mcen_d;

        always_ff @(posedge clk) begin
            if (rst) state_q <= IDLE;
            else     state_q <= state_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q        <= 1'b0;
                s2_q        <= 1'b0;
                cnt_q       <= '0;
                rep_q       <= '0;
                rep_phase_q <= 1'b0;
                db_q        <= 1'b0;
                scen_q      <= 1'b0;
                mcen_q      <= 1'b0;
            end else begin
                s1_q        <= btn_raw[i];
                s2_q        <= s1_q;
                cnt_q       <= cnt_d;
                rep_q       <= rep_d;
                rep_phase_q <= rep_phase_d;
                db_q        <= db_d;
                scen_q      <= scen_d;
                mcen_q      <= mcen_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:         if (s2_q) state_d = PRESS_WAIT;
                PRESS_WAIT:   if (!s2_q) state_d = IDLE;
                              else if (cnt_q == DB_CNT) state_d = PRESSED;
                PRESSED:      if (!s2_q) state_d = RELEASE_WAIT;
                RELEASE_WAIT: if (s2_q) state_d = PRESSED;
                              else if (cnt_q == DB_CNT) state_d = IDLE;
                default:      state_d = IDLE;
            endcase
        end

        // rep_phase selects the first (delay) or subsequent (period) repeat interval;
        // rep restarts at every pulse so it never exceeds the larger interval.
        always_comb begin
            rep_inc     = rep_q + CNT_ONE;
            rep_target  = rep_phase_q ? RP_CNT : RD_CNT;
            rep_d       = '0;
            rep_phase_d = 1'b0;
            scen_d      = 1'b0;
            mcen_d      = 1'b0;
            cnt_d       = '0;
            db_d        = (state_d == PRESSED) || (state_d == RELEASE_WAIT);

            if ((state_d == PRESS_WAIT) || (state_d == RELEASE_WAIT))
                cnt_d = (state_d != state_q) ? CNT_ONE : cnt_q + CNT_ONE;

            if (state_d == PRESSED) begin
                if (state_q != PRESSED) begin
                    // a bounce back from RELEASE_WAIT only restarts the repeat timer
                    scen_d = (state_q == PRESS_WAIT);
                    mcen_d = (state_q == PRESS_WAIT);
                end else if (rep_inc == rep_target) begin
                    rep_phase_d = 1'b1;
                    mcen_d      = 1'b1;
                end else begin
                    rep_d       = rep_inc;
                    rep_phase_d = rep_phase_q;
                end
            end
        end

        assign btn_db[i]   = db_q;
        assign btn_scen[i] = scen_q;
        assign btn_mcen[i] = mcen_q;
    end

endmodule
